gf180mcu_fd_sc_mcu7t5v0__invseg_seq: RTL and testbench
======================================================

GF180MCU_FD_SC_MCU7T5V0__INVSEG_SEQ -- requirements
Module: gf180mcu_fd_sc_mcu7t5v0__invseg_seq

Interface
REQ-001 SHALL have parameter NSEG, default 4, number of parallel inverter segments driven; legal 2..16.
REQ-002 SHALL have parameter STEP_CYC, default 2, clock cycles between successive segment steps; legal 1..15.
REQ-003 SHALL have port CLK  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port EN  input  1  sequencer enable; low freezes all state.
REQ-006 SHALL have port D  input  1  requested logic level for the segmented driver input.
REQ-007 SHALL have port SEG  output  NSEG  thermometer-coded I inputs of the downstream inverter segments; bit 0 switches first.
REQ-008 SHALL have port BUSY  output  1  high while a ramp is in progress.
REQ-009 SHALL have port DONE  output  1  single-cycle pulse when SEG reaches its target.
REQ-010 SHALL have ports VDD and VSS  inout  1  supply pins; no functional use.

Function
REQ-011 SHALL use one clock and a synchronous, active-high reset.
REQ-012 SHALL register SEG, BUSY, DONE; no combinational path from inputs to outputs.
REQ-013 SHALL keep SEG thermometer-coded (contiguous ones from bit 0) at all times.
REQ-014 SHALL define target as all-ones when D=1, all-zeros when D=0.
REQ-015 SHALL implement states IDLE, RAMP_UP, RAMP_DN.
REQ-016 IDLE: at an edge with EN=1 and SEG != target, SHALL step SEG one segment toward target at that edge, enter RAMP_UP (D=1) or RAMP_DN (D=0), set BUSY=1, load step timer to 0.
REQ-017 RAMP_UP step: set lowest clear bit; RAMP_DN step: clear highest set bit; exactly one bit changes per step.
REQ-018 In RAMP states, timer SHALL increment each enabled cycle; the next step SHALL occur at the edge where timer reaches STEP_CYC-1, then timer reloads to 0; with STEP_CYC=1, one step per cycle.
REQ-019 Full transition SHALL complete at edge t+(NSEG-1)*STEP_CYC, t being the first-step edge.
REQ-020 At the edge where the final step makes SEG equal target, SHALL return to IDLE, set BUSY=0, DONE=1 for exactly the following cycle.
REQ-021 Reversal: if D changes during a ramp, SHALL at that edge reverse direction, step one segment toward the new target immediately, reload timer to 0, keep BUSY=1; no DONE for the abandoned target.
REQ-022 D toggling back and forth faster than STEP_CYC SHALL give one step per reversal edge, SEG never leaving thermometer code.
REQ-023 EN=0 SHALL hold SEG, state, timer, BUSY; DONE SHALL be 0; D is re-evaluated on the first edge EN=1.
REQ-024 In IDLE with SEG equal target, outputs SHALL stay static, DONE=0.

Reset
REQ-025 RST=1 at an edge SHALL force SEG=0, BUSY=0, DONE=0, timer=0, state IDLE, overriding EN and D.
REQ-026 RST asserted mid-ramp SHALL abort the ramp without DONE; after release, with D=1, a new ramp SHALL start from SEG=0 on the first edge RST=0 and EN=1.

Verification
REQ-027 NSEG=4, STEP_CYC=2, EN=1, D 0->1 before edge 0 -> SEG 0001@e0, 0011@e2, 0111@e4, 1111@e6; BUSY 1 after e0..e5; DONE=1 only cycle after e6.
REQ-028 From SEG=1111, D 1->0 -> SEG 0111, 0011, 0001, 0000 at e0, e2, e4, e6; DONE one cycle after e6.
REQ-029 D 0->1 at e0, back to 0 before e3 -> SEG 0001@e0, 0011@e2, 0001@e3, 0000@e5; single DONE after e5, none for abandoned ramp.
REQ-030 Mid-ramp SEG=0011, EN=0 for 5 cycles -> SEG, BUSY frozen, DONE=0; after EN=1, remaining steps keep STEP_CYC spacing from frozen timer value.
REQ-031 Mid-ramp SEG=0111, RST=1 one cycle -> SEG=0000, BUSY=0, DONE=0 next cycle; with D=1 held, SEG=0001 on first edge after RST release.
REQ-032 STEP_CYC=1, NSEG=8, D 0->1 -> SEG gains one bit per edge, 11111111 after 8 edges, DONE one cycle; checker asserts thermometer code every cycle in all scenarios.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__invseg_seq.sv
// Sequenced drive for a segmented inverter: ramps a thermometer-coded
// segment enable one segment per STEP_CYC cycles toward the level on D.
module gf180mcu_fd_sc_mcu7t5v0__invseg_seq #(
    parameter int NSEG     = 4,
    parameter int STEP_CYC = 2
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            EN,
    input  logic            D,
    output logic [NSEG-1:0] SEG,
    output logic            BUSY,
    output logic            DONE,
    inout  wire             VDD,
    inout  wire             VSS
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAMP_UP = 2'd1,
        RAMP_DN = 2'd2
    } state_t;

    localparam logic [3:0] LAST = 4'(STEP_CYC - 1);

    state_t          state;
    logic [3:0]      timer;
    logic [NSEG-1:0] target;
    logic [NSEG-1:0] seg_step;
    logic            reversing;
    logic            step_due;

    // Supply pins are carried for netlist compatibility only.
    wire unused_supply = VDD ^ VSS;

    // Shifting keeps the code thermometer: one bit changes per step.
    always_comb begin
        target    = {NSEG{D}};
        seg_step  = D ? {SEG[NSEG-2:0], 1'b1} : {1'b0, SEG[NSEG-1:1]};
        reversing = (state == RAMP_UP) != D;
        step_due  = reversing || (timer == LAST);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            timer <= '0;
            SEG   <= '0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
        end else if (!EN) begin
            DONE <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (SEG != target) begin
                        SEG   <= seg_step;
                        timer <= '0;
                        if (seg_step == target) begin
                            DONE <= 1'b1;
                        end else begin
                            BUSY  <= 1'b1;
                            state <= D ? RAMP_UP : RAMP_DN;
                        end
                    end
                end
                default: begin
                    if (step_due) begin
                        SEG   <= seg_step;
                        timer <= '0;
                        if (seg_step == target) begin
                            state <= IDLE;
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                        end else begin
                            state <= D ? RAMP_UP : RAMP_DN;
                        end
                    end else begin
                        timer <= timer + 4'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__invseg_seq.sv
// Directed vector bench for the segmented inverter sequencer.
// Covers ramps, reversal, freeze, reset abort and a fast 8-segment ramp.
module tb_gf180mcu_fd_sc_mcu7t5v0__invseg_seq;

    typedef struct {
        logic       rst;
        logic       en;
        logic       d;
        logic [3:0] seg;
        logic       busy;
        logic       done;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_a = 1'b1, en_a = 1'b0, d_a = 1'b0;
    logic       rst_b = 1'b1, en_b = 1'b0, d_b = 1'b0;
    logic [3:0] seg_a;
    logic [7:0] seg_b;
    logic       busy_a, done_a, busy_b, done_b;
    wire        vdd = 1'b1;
    wire        vss = 1'b0;

    int   applied = 0;
    int   miscompares = 0;
    vec_t vt[$];

    always #5 clk = ~clk;

    gf180mcu_fd_sc_mcu7t5v0__invseg_seq #(.NSEG(4), .STEP_CYC(2)) dut_a (
        .CLK(clk), .RST(rst_a), .EN(en_a), .D(d_a),
        .SEG(seg_a), .BUSY(busy_a), .DONE(done_a),
        .VDD(vdd), .VSS(vss)
    );

    gf180mcu_fd_sc_mcu7t5v0__invseg_seq #(.NSEG(8), .STEP_CYC(1)) dut_b (
        .CLK(clk), .RST(rst_b), .EN(en_b), .D(d_b),
        .SEG(seg_b), .BUSY(busy_b), .DONE(done_b),
        .VDD(vdd), .VSS(vss)
    );

    function automatic void add(input logic r, e, dd,
                                input logic [3:0] s,
                                input logic b, dn);
        vec_t v;
        v.rst = r; v.en = e; v.d = dd;
        v.seg = s; v.busy = b; v.done = dn;
        vt.push_back(v);
    endfunction

    // Thermometer code must hold on every cycle for both instances.
    always @(negedge clk) begin
        applied++;
        if (((seg_a + 4'd1) & seg_a) != 4'd0) begin
            miscompares++;
            $display("FAIL therm_a seg=%b is not thermometer", seg_a);
        end
        if (((seg_b + 8'd1) & seg_b) != 8'd0) begin
            miscompares++;
            $display("FAIL therm_b seg=%b is not thermometer", seg_b);
        end
    end

    initial begin
        // reset
        add(1,1,1, 4'b0000,0,0);
        add(1,0,0, 4'b0000,0,0);
        // ramp up 0 -> 1111
        add(0,1,1, 4'b0001,1,0);
        add(0,1,1, 4'b0001,1,0);
        add(0,1,1, 4'b0011,1,0);
        add(0,1,1, 4'b0011,1,0);
        add(0,1,1, 4'b0111,1,0);
        add(0,1,1, 4'b0111,1,0);
        add(0,1,1, 4'b1111,0,1);
        add(0,1,1, 4'b1111,0,0);
        add(0,1,1, 4'b1111,0,0);
        // ramp down 1111 -> 0
        add(0,1,0, 4'b0111,1,0);
        add(0,1,0, 4'b0111,1,0);
        add(0,1,0, 4'b0011,1,0);
        add(0,1,0, 4'b0011,1,0);
        add(0,1,0, 4'b0001,1,0);
        add(0,1,0, 4'b0001,1,0);
        add(0,1,0, 4'b0000,0,1);
        add(0,1,0, 4'b0000,0,0);
        // abandoned up ramp reversed before e3
        add(0,1,1, 4'b0001,1,0);
        add(0,1,1, 4'b0001,1,0);
        add(0,1,1, 4'b0011,1,0);
        add(0,1,0, 4'b0001,1,0);
        add(0,1,0, 4'b0001,1,0);
        add(0,1,0, 4'b0000,0,1);
        add(0,1,0, 4'b0000,0,0);
        // freeze mid-ramp with timer=1, D wiggles while frozen
        add(0,1,1, 4'b0001,1,0);
        add(0,1,1, 4'b0001,1,0);
        add(0,1,1, 4'b0011,1,0);
        add(0,1,1, 4'b0011,1,0);
        add(0,0,1, 4'b0011,1,0);
        add(0,0,0, 4'b0011,1,0);
        add(0,0,1, 4'b0011,1,0);
        add(0,0,0, 4'b0011,1,0);
        add(0,0,1, 4'b0011,1,0);
        add(0,1,1, 4'b0111,1,0);
        add(0,1,1, 4'b0111,1,0);
        add(0,1,1, 4'b1111,0,1);
        add(0,1,1, 4'b1111,0,0);
        // reset abort at 0111, restart from 0
        add(1,1,1, 4'b0000,0,0);
        add(0,1,1, 4'b0001,1,0);
        add(0,1,1, 4'b0001,1,0);
        add(0,1,1, 4'b0011,1,0);
        add(0,1,1, 4'b0011,1,0);
        add(0,1,1, 4'b0111,1,0);
        add(1,1,1, 4'b0000,0,0);
        add(0,1,1, 4'b0001,1,0);
        add(0,1,1, 4'b0001,1,0);
        add(0,1,1, 4'b0011,1,0);
        // EN low in idle, then freeze on the final step
        add(1,1,1, 4'b0000,0,0);
        add(0,0,1, 4'b0000,0,0);
        add(0,1,1, 4'b0001,1,0);
        add(0,1,1, 4'b0001,1,0);
        add(0,1,1, 4'b0011,1,0);
        add(0,1,1, 4'b0011,1,0);
        add(0,1,1, 4'b0111,1,0);
        add(0,1,1, 4'b0111,1,0);
        add(0,0,1, 4'b0111,1,0);
        add(0,1,1, 4'b1111,0,1);
        add(0,1,1, 4'b1111,0,0);
        // rapid D toggling: one step per reversal edge
        add(1,1,0, 4'b0000,0,0);
        add(0,1,1, 4'b0001,1,0);
        add(0,1,1, 4'b0001,1,0);
        add(0,1,1, 4'b0011,1,0);
        add(0,1,1, 4'b0011,1,0);
        add(0,1,0, 4'b0001,1,0);
        add(0,1,1, 4'b0011,1,0);
        add(0,1,0, 4'b0001,1,0);
        add(0,1,1, 4'b0011,1,0);
        add(0,1,1, 4'b0011,1,0);
        add(0,1,1, 4'b0111,1,0);
        add(0,1,1, 4'b0111,1,0);
        add(0,1,1, 4'b1111,0,1);
        add(0,1,1, 4'b1111,0,0);

        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clk);
            rst_a = vt[i].rst;
            en_a  = vt[i].en;
            d_a   = vt[i].d;
            @(posedge clk);
            #1;
            applied++;
            if (seg_a !== vt[i].seg || busy_a !== vt[i].busy ||
                done_a !== vt[i].done) begin
                miscompares++;
                $display("FAIL vec%0d seg/busy/done=%b/%b/%b want %b/%b/%b",
                         i, seg_a, busy_a, done_a,
                         vt[i].seg, vt[i].busy, vt[i].done);
            end
        end

        // NSEG=8, STEP_CYC=1: one bit per edge, DONE once
        @(negedge clk);
        rst_b = 1'b1; en_b = 1'b1; d_b = 1'b1;
        @(posedge clk);
        #1;
        applied++;
        if (seg_b !== 8'h00 || busy_b !== 1'b0 || done_b !== 1'b0) begin
            miscompares++;
            $display("FAIL b_reset seg/busy/done=%b/%b/%b want 0/0/0",
                     seg_b, busy_b, done_b);
        end
        @(negedge clk);
        rst_b = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            logic [7:0] es;
            logic       eb, ed;
            es = (k >= 8) ? 8'hff : 8'((16'd1 << k) - 16'd1);
            eb = (k < 8);
            ed = (k == 8);
            @(posedge clk);
            #1;
            applied++;
            if (seg_b !== es || busy_b !== eb || done_b !== ed) begin
                miscompares++;
                $display("FAIL b_ramp%0d seg/busy/done=%b/%b/%b want %b/%b/%b",
                         k, seg_b, busy_b, done_b, es, eb, ed);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 applied, miscompares);
        $finish;
    end

endmodule
